// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the unified-memory port arbiter: the arbiter
//   state encoding and the default address/data widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // IDLE  : no transaction in flight
    // IBUSY : instruction fetch in flight
    // DBUSY : load/store in flight
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arbState_t;

endpackage

// File: rtl/arb_stall_counter.sv
// arb_stall_counter
//   Free-running 32-bit event counter. Increments on every clock where
//   'enable' is high and wraps from all-ones back to zero.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous, active-high reset (count -> 0)
//   enable in   count this cycle
//   count  out  current count
module arb_stall_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [31:0] count
);

    // Plain modulo-2^32 addition gives the wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch stage (F) and
//   the memory stage (M). One transaction at a time; data has priority over
//   fetch. Produces the memory stall requests for the hazard unit and drops
//   wrong-path fetch data after a redirect.
//
// Memory handshake: MemValid is high for the whole life of a transaction and
//   MemAddr/MemWData/MemWe are held constant while it is high; the
//   transaction completes in the cycle where MemValid & MemReady, and
//   MemRData is only meaningful in that cycle. MemValid may rise again in the
//   very next cycle when a chained request is pending.
//
// Ports:
//   clk, rst                          clock / async active-high reset
//   IReqF, PCF                        fetch request and address
//   Redirect                          taken branch/jump in E
//   DReqM, DWeM, ALUResultM, WriteDataM  load/store request from M
//   MemValid, MemAddr, MemWData, MemWe   request side of memory port
//   MemReady, MemRData                completion side of memory port
//   InstrF, InstrValidF               fetched instruction to F
//   ReadDataM, DataValidM             load data / store done to M
//   MemStallF, MemStallM              stall requests to the hazard unit
//   StateDbg                          current arbiter state (observation)
//   IStallCnt, DStallCnt              stall cycle counters (ARB_PERF_CNT_EN)
//
// Build option: define ARB_PERF_CNT_EN to add the stall cycle counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IReqF,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              Redirect,
    input  logic              DReqM,
    input  logic              DWeM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              MemValid,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWe,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] MemRData,
    output logic [DATA_W-1:0] InstrF,
    output logic              InstrValidF,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              DataValidM,
    output logic              MemStallF,
    output logic              MemStallM,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       IStallCnt,
    output logic [31:0]       DStallCnt,
`endif
    output arbState_t         StateDbg
);

    arbState_t state, stateNext;
    logic      drop, dropNext;
    logic      grantI, grantD;
    logic      iDone, dDone;

    assign iDone = (state == IBUSY) && MemReady;
    assign dDone = (state == DBUSY) && MemReady;

    // Next-state / grant decode.
    always_comb begin
        stateNext = state;
        dropNext  = drop;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                if (DReqM) begin
                    stateNext = DBUSY;
                    grantD    = 1'b1;
                end else if (IReqF && !Redirect) begin
                    stateNext = IBUSY;
                    grantI    = 1'b1;
                end
            end
            DBUSY: begin
                if (MemReady) begin
                    if (IReqF) begin
                        stateNext = IBUSY;
                        grantI    = 1'b1;
                        // E is released in this cycle, so a redirect seen now
                        // means PCF is still the wrong-path address.
                        dropNext  = Redirect;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            IBUSY: begin
                if (Redirect) begin
                    dropNext = 1'b1;
                end
                if (MemReady) begin
                    // Memory cannot abort, so the drop flag only ends here.
                    dropNext = 1'b0;
                    if (DReqM) begin
                        stateNext = DBUSY;
                        grantD    = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                dropNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= stateNext;
            drop  <= dropNext;
        end
    end

    // Transaction registers load only on a grant and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemAddr  <= '0;
            MemWData <= '0;
            MemWe    <= 1'b0;
        end else if (grantD) begin
            MemAddr  <= ALUResultM;
            MemWData <= WriteDataM;
            MemWe    <= DWeM;
        end else if (grantI) begin
            MemAddr  <= PCF;
            MemWData <= '0;
            MemWe    <= 1'b0;
        end
    end

    assign MemValid    = (state != IDLE);
    assign InstrF      = MemRData;
    assign ReadDataM   = MemRData;
    assign InstrValidF = iDone && !drop && !Redirect;
    assign DataValidM  = dDone;
    assign MemStallM   = DReqM && !dDone;
    assign MemStallF   = MemStallM || (IReqF && !iDone);
    assign StateDbg    = state;

`ifdef ARB_PERF_CNT_EN
    arb_stall_counter uIStallCnt (
        .clk    (clk),
        .rst    (rst),
        .enable (MemStallF && !MemStallM),
        .count  (IStallCnt)
    );

    arb_stall_counter uDStallCnt (
        .clk    (clk),
        .rst    (rst),
        .enable (MemStallM),
        .count  (DStallCnt)
    );
`endif

endmodule
